data_chunk_top: RTL and testbench
=================================

// Module: data_chunk_top
// PURPOSE
//  Sparse operand buffer for one MEM_SIZE-byte dense chunk (IFM or filter) in the NPU input selector.
//  Stores a 1-bit-per-byte sparsemap plus the packed nonzero bytes. Serves sparsemap windows to the
//  priority encoder and returns the nonzero byte addressed by the encoder's match (prefix-sum lookup).
// PARAMETERS
//  MEM_SIZE         128  dense chunk size in bytes = sparsemap bits = nonzero-byte capacity
//  BUS_SIZE         8    dense bytes per write beat (sparsemap bits per beat)
//  PREFIX_SUM_SIZE  8    sparsemap window width per read step
//  All parameters are powers of two; MEM_SIZE is a multiple of BUS_SIZE and of PREFIX_SUM_SIZE.
// PORTS
//  clk_i                 in   1                          single clock, all state on rising edge
//  rst_i                 in   1                          reset, asynchronous, active-low
//  wr_sparsemap_i        in   BUS_SIZE                   sparsemap of beat; bit k=1 means dense byte k is nonzero
//  wr_nonzero_data_i     in   BUS_SIZE*8                 packed nonzero bytes, first nonzero in [7:0]
//  wr_valid_i            in   1                          write beat valid
//  wr_ready_o            out  1                          buffer accepts beats (not full)
//  refresh_mem_i         in   1                          1: empty the buffer at chunk_end_i; 0: keep contents
//  rd_data_o             out  8                          nonzero byte selected by match
//  rd_ready_o            out  1                          chunk fully loaded, readable
//  pri_enc_match_addr_i  in   $clog2(PREFIX_SUM_SIZE)    matched bit position inside current window
//  pri_enc_end_i         in   1                          encoder finished current window
//  chunk_end_i           in   1                          last window of chunk finished
//  rd_sparsemap_addr_i   in   $clog2(MEM_SIZE/PREFIX_SUM_SIZE)  window index
//  rd_sparsemap_o        out  PREFIX_SUM_SIZE            sparsemap window
// BEHAVIOUR
//  Reset (rst_i=0, async): sparsemap, data memory, pointers, base_r, full_r cleared
//   -> wr_ready_o=1, rd_ready_o=0, rd_sparsemap_o=0, rd_data_o=0.
//  Write: beat accepted when wr_valid_i && wr_ready_o. Sparsemap bits stored at
//   sm[wr_beat*BUS_SIZE +: BUS_SIZE]; first popcount(wr_sparsemap_i) bytes of wr_nonzero_data_i
//   stored at data[nz_ptr ...]; nz_ptr += popcount; wr_beat += 1. Unused lanes ignored.
//  After beat MEM_SIZE/BUS_SIZE-1 is accepted, full_r=1 next cycle: wr_ready_o=0, rd_ready_o=1.
//   wr_ready_o = !full_r, rd_ready_o = full_r (both registered-state derived, no comb path from wr_valid_i).
//  Beats presented while full are ignored (no state change).
//  Read (combinational): rd_sparsemap_o = sm[rd_sparsemap_addr_i*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE].
//   rd_data_o = data[base_r + popcount(rd_sparsemap_o[pri_enc_match_addr_i-1:0])] (term 0 when match=0).
//  base_r (width $clog2(MEM_SIZE)+1): on pri_enc_end_i && !chunk_end_i, base_r += popcount(rd_sparsemap_o);
//   on chunk_end_i, base_r = 0. Caller advances rd_sparsemap_addr_i on the same edge.
//  chunk_end_i && refresh_mem_i: full_r=0, wr_beat=0, nz_ptr=0, sparsemap cleared -> refill next cycle.
//  chunk_end_i && !refresh_mem_i: contents kept, rd_ready_o stays 1 (stationary reuse).
//  Priority: reset > chunk_end_i refresh > write. Write and refresh-clear never coincide (wr_ready_o=0 when full).
//  Reads while rd_ready_o=0 return current memory contents; caller must not use them.
//  All-zero chunk: loads normally, every window = 0, rd_data_o = data[0].
// TESTING
//  Reset: rst_i low mid-load (4 beats in) -> wr_ready_o=1, rd_ready_o=0, sparsemap/pointers 0 next edge.
//  Dense load: 16 beats sm=8'hFF, data bytes = index 0..127 -> rd_ready_o=1 after beat 16; window 3
//   match 5 after three pri_enc_end_i pulses -> rd_data_o=29.
//  Sparse load: beat0 sm=8'b1001_0010, data {..,8'h33,8'h22,8'h11} -> rd_sparsemap_o(addr0)=8'h92;
//   match 1->8'h11, match 4->8'h22, match 7->8'h33.
//  Backpressure: wr_valid_i held after full -> beat 17 ignored, wr_ready_o=0, contents unchanged.
//  Refresh: chunk_end_i with refresh_mem_i=1 -> rd_ready_o=0, wr_ready_o=1 next cycle, base_r=0;
//   with refresh_mem_i=0 -> rd_ready_o stays 1, addr0 window unchanged.
//  base_r: windows popcounts 3,0,8 with pri_enc_end_i each -> base_r 3,3,11; chunk_end_i -> 0.

Source files
------------

// File: rtl/data_chunk_if.sv
// Bus bundle for one sparse operand buffer: write beats in, sparsemap windows
// and selected nonzero bytes out.
interface data_chunk_if #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 8,
    parameter int PREFIX_SUM_SIZE = 8
);
    logic [BUS_SIZE-1:0]                          wr_sparsemap_i;
    logic [BUS_SIZE*8-1:0]                        wr_nonzero_data_i;
    logic                                         wr_valid_i;
    logic                                         wr_ready_o;
    logic                                         refresh_mem_i;
    logic [7:0]                                   rd_data_o;
    logic                                         rd_ready_o;
    logic [$clog2(PREFIX_SUM_SIZE)-1:0]           pri_enc_match_addr_i;
    logic                                         pri_enc_end_i;
    logic                                         chunk_end_i;
    logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0]  rd_sparsemap_addr_i;
    logic [PREFIX_SUM_SIZE-1:0]                   rd_sparsemap_o;

    // buffer side
    modport slave (
        input  wr_sparsemap_i, wr_nonzero_data_i, wr_valid_i, refresh_mem_i,
        input  pri_enc_match_addr_i, pri_enc_end_i, chunk_end_i, rd_sparsemap_addr_i,
        output wr_ready_o, rd_data_o, rd_ready_o, rd_sparsemap_o
    );

    // loader / priority-encoder side
    modport master (
        output wr_sparsemap_i, wr_nonzero_data_i, wr_valid_i, refresh_mem_i,
        output pri_enc_match_addr_i, pri_enc_end_i, chunk_end_i, rd_sparsemap_addr_i,
        input  wr_ready_o, rd_data_o, rd_ready_o, rd_sparsemap_o
    );
endinterface

// File: rtl/data_chunk_top.sv
// Sparse operand buffer: holds one dense chunk as a sparsemap plus packed
// nonzero bytes, and resolves encoder matches to bytes via a prefix-sum lookup.
module data_chunk_top #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 8,
    parameter int PREFIX_SUM_SIZE = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    data_chunk_if.slave bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int BW = $clog2(MEM_SIZE/BUS_SIZE);
    localparam int MW = $clog2(PREFIX_SUM_SIZE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MEM_SIZE/BUS_SIZE - 1);

    logic [MEM_SIZE-1:0]        sm;
    logic [7:0]                 mem [MEM_SIZE];
    logic [BW-1:0]              wr_beat;
    logic [AW:0]                nz_ptr;
    logic [AW:0]                base_r;
    logic                       full_r;

    logic                       do_clear;
    logic                       wr_fire;
    logic [AW:0]                beat_cnt;
    logic [AW:0]                win_cnt;
    logic [AW:0]                below_cnt;
    logic [PREFIX_SUM_SIZE-1:0] win;
    logic [PREFIX_SUM_SIZE-1:0] below;
    logic [AW-1:0]              rd_addr;

    function automatic logic [AW:0] popcount_bus(input logic [BUS_SIZE-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < BUS_SIZE; i++) cnt = cnt + {{AW{1'b0}}, v[i]};
        return cnt;
    endfunction

    function automatic logic [AW:0] popcount_win(input logic [PREFIX_SUM_SIZE-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < PREFIX_SUM_SIZE; i++) cnt = cnt + {{AW{1'b0}}, v[i]};
        return cnt;
    endfunction

    // Refresh at chunk end outranks a write; the two cannot coincide in normal use
    // because writes are only accepted while not full.
    assign do_clear = bus.chunk_end_i && bus.refresh_mem_i;
    assign wr_fire  = bus.wr_valid_i && !full_r && !do_clear;
    assign beat_cnt = popcount_bus(bus.wr_sparsemap_i);

    assign bus.wr_ready_o = !full_r;
    assign bus.rd_ready_o = full_r;

    // Read path: current window, count of set bits below the match, byte lookup.
    assign win = sm[bus.rd_sparsemap_addr_i*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE];
    assign bus.rd_sparsemap_o = win;
    assign win_cnt = popcount_win(win);

    // Mask off window bits at or above the match position.
    always_comb begin
        below = '0;
        for (int i = 0; i < PREFIX_SUM_SIZE; i++)
            below[i] = win[i] && (MW'(i) < bus.pri_enc_match_addr_i);
    end

    assign below_cnt     = popcount_win(below);
    assign rd_addr       = base_r[AW-1:0] + below_cnt[AW-1:0];
    assign bus.rd_data_o = mem[rd_addr];

    // Sparsemap, write pointers and full flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sm      <= '0;
            wr_beat <= '0;
            nz_ptr  <= '0;
            full_r  <= 1'b0;
        end else if (do_clear) begin
            sm      <= '0;
            wr_beat <= '0;
            nz_ptr  <= '0;
            full_r  <= 1'b0;
        end else if (wr_fire) begin
            sm[wr_beat*BUS_SIZE +: BUS_SIZE] <= bus.wr_sparsemap_i;
            wr_beat <= wr_beat + 1'b1;
            nz_ptr  <= nz_ptr + beat_cnt;
            if (wr_beat == LAST_BEAT) full_r <= 1'b1;
        end
    end

    // Packed nonzero bytes: only the first popcount lanes of a beat are stored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= '0;
        end else if (wr_fire) begin
            for (int k = 0; k < BUS_SIZE; k++)
                if ((AW+1)'(k) < beat_cnt)
                    mem[nz_ptr[AW-1:0] + AW'(k)] <= bus.wr_nonzero_data_i[k*8 +: 8];
        end
    end

    // Window base offset into the packed bytes; rewinds at every chunk end.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            base_r <= '0;
        else if (bus.chunk_end_i)
            base_r <= '0;
        else if (bus.pri_enc_end_i)
            base_r <= base_r + win_cnt;
    end
endmodule

// File: tb/tb_data_chunk_top.sv
module tb_data_chunk_top;
    localparam int K_DATA = 0;
    localparam int K_SM   = 1;
    localparam int K_WRDY = 2;
    localparam int K_RRDY = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] act;

    data_chunk_if #(.MEM_SIZE(128), .BUS_SIZE(8), .PREFIX_SUM_SIZE(8)) bus ();

    data_chunk_top #(.MEM_SIZE(128), .BUS_SIZE(8), .PREFIX_SUM_SIZE(8)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Monitor: at every falling edge compare all pending expectations.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.kind)
                K_DATA:  act = {24'd0, bus.rd_data_o};
                K_SM:    act = {24'd0, bus.rd_sparsemap_o};
                K_WRDY:  act = {31'd0, bus.wr_ready_o};
                default: act = {31'd0, bus.rd_ready_o};
            endcase
            n_cmp++;
            if (act !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s: actual=%0h required=%0h", mon_e.name, act, mon_e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Let the monitor consume pending expectations over one idle cycle.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string name, input logic [3:0] addr, input logic [2:0] match,
                         input logic [7:0] exp_data);
        bus.rd_sparsemap_addr_i  = addr;
        bus.pri_enc_match_addr_i = match;
        expect_val(name, K_DATA, {24'd0, exp_data});
        settle();
    endtask

    task automatic beat(input logic [7:0] sm, input logic [63:0] data);
        bus.wr_sparsemap_i    = sm;
        bus.wr_nonzero_data_i = data;
        bus.wr_valid_i        = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_valid_i        = 1'b0;
    endtask

    task automatic dense_beat(input int b);
        logic [63:0] d;
        for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(b*8 + j);
        beat(8'hFF, d);
    endtask

    task automatic pri_end(input logic [3:0] addr);
        bus.rd_sparsemap_addr_i = addr;
        bus.pri_enc_end_i       = 1'b1;
        @(posedge clk);
        #1;
        bus.pri_enc_end_i       = 1'b0;
        bus.rd_sparsemap_addr_i = addr + 4'd1;
    endtask

    task automatic chunk_end(input logic refresh);
        bus.refresh_mem_i       = refresh;
        bus.chunk_end_i         = 1'b1;
        @(posedge clk);
        #1;
        bus.chunk_end_i         = 1'b0;
        bus.refresh_mem_i       = 1'b0;
        bus.rd_sparsemap_addr_i = 4'd0;
    endtask

    initial begin
        int waited;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.wr_sparsemap_i       = '0;
        bus.wr_nonzero_data_i    = '0;
        bus.wr_valid_i           = 1'b0;
        bus.refresh_mem_i        = 1'b0;
        bus.pri_enc_match_addr_i = '0;
        bus.pri_enc_end_i        = 1'b0;
        bus.chunk_end_i          = 1'b0;
        bus.rd_sparsemap_addr_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        expect_val("rst_wr_ready", K_WRDY, 32'd1);
        expect_val("rst_rd_ready", K_RRDY, 32'd0);
        expect_val("rst_sm0", K_SM, 32'h00);
        expect_val("rst_data", K_DATA, 32'h00);
        settle();

        // reset in the middle of a load
        for (int b = 0; b < 4; b++) dense_beat(b);
        expect_val("midload_sm0_before", K_SM, 32'hFF);
        settle();
        rst_n = 1'b0;
        #1;
        expect_val("midrst_wr_ready", K_WRDY, 32'd1);
        expect_val("midrst_rd_ready", K_RRDY, 32'd0);
        expect_val("midrst_sm0", K_SM, 32'h00);
        settle();
        rst_n = 1'b1;
        bus.rd_sparsemap_addr_i = 4'd3;
        expect_val("midrst_sm3", K_SM, 32'h00);
        expect_val("midrst_data", K_DATA, 32'h00);
        settle();

        // dense load
        for (int b = 0; b < 15; b++) dense_beat(b);
        expect_val("dense_not_full", K_RRDY, 32'd0);
        settle();
        dense_beat(15);
        waited = 0;
        while (!bus.rd_ready_o && waited < 5) begin
            @(posedge clk);
            #1;
            waited++;
        end
        expect_val("dense_rd_ready", K_RRDY, 32'd1);
        expect_val("dense_wr_ready", K_WRDY, 32'd0);
        bus.rd_sparsemap_addr_i = 4'd15;
        expect_val("dense_sm15", K_SM, 32'hFF);
        settle();
        probe("dense_w0_m0", 4'd0, 3'd0, 8'd0);
        probe("dense_w0_m7", 4'd0, 3'd7, 8'd7);
        pri_end(4'd0);
        pri_end(4'd1);
        pri_end(4'd2);
        probe("dense_w3_m5", 4'd3, 3'd5, 8'd29);

        // backpressure: beats while full are dropped
        bus.wr_sparsemap_i    = 8'h00;
        bus.wr_nonzero_data_i = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.wr_valid_i        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_val("bp_wr_ready", K_WRDY, 32'd0);
        bus.rd_sparsemap_addr_i = 4'd0;
        expect_val("bp_sm0", K_SM, 32'hFF);
        settle();
        bus.wr_valid_i = 1'b0;
        probe("bp_w3_m5", 4'd3, 3'd5, 8'd29);

        // stationary reuse
        chunk_end(1'b0);
        expect_val("keep_rd_ready", K_RRDY, 32'd1);
        expect_val("keep_sm0", K_SM, 32'hFF);
        settle();
        probe("keep_w0_m3", 4'd0, 3'd3, 8'd3);

        // refresh
        chunk_end(1'b1);
        expect_val("refresh_rd_ready", K_RRDY, 32'd0);
        expect_val("refresh_wr_ready", K_WRDY, 32'd1);
        expect_val("refresh_sm0", K_SM, 32'h00);
        settle();

        // sparse load: windows with popcounts 3, 0, 8, then zeros
        beat(8'b1001_0010, {40'hAA_AAAA_AAAA, 24'h33_2211});
        beat(8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(8'hFF, 64'h4746_4544_4342_4140);
        for (int b = 3; b < 16; b++) beat(8'h00, 64'h0);
        expect_val("sparse_rd_ready", K_RRDY, 32'd1);
        bus.rd_sparsemap_addr_i = 4'd0;
        expect_val("sparse_sm0", K_SM, 32'h92);
        settle();
        bus.rd_sparsemap_addr_i = 4'd1;
        expect_val("sparse_sm1", K_SM, 32'h00);
        settle();
        probe("sparse_m1", 4'd0, 3'd1, 8'h11);
        probe("sparse_m4", 4'd0, 3'd4, 8'h22);
        probe("sparse_m7", 4'd0, 3'd7, 8'h33);

        // base offset walk
        pri_end(4'd0);
        probe("base3_w1", 4'd1, 3'd0, 8'h40);
        pri_end(4'd1);
        probe("base3_w2_m0", 4'd2, 3'd0, 8'h40);
        probe("base3_w2_m5", 4'd2, 3'd5, 8'h45);
        pri_end(4'd2);
        probe("base11_w3", 4'd3, 3'd0, 8'd11);
        chunk_end(1'b0);
        probe("base0_w0", 4'd0, 3'd0, 8'h11);

        settle();
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: actual=%0d pending required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
